prbs_checker: RTL



---
 rtl/prbs_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prbs_checker                                              |
// | Brief    : Self-synchronising serial PRBS checker with lock/loss     |
// |            detection, per-error pulse and saturating counters.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module prbs_checker #(
    parameter int LFSR_W      = 7,
    parameter int TAP_A       = 7,
    parameter int TAP_B       = 6,
    parameter int LOCK_CNT    = 8,
    parameter int WIN         = 64,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int c_FILL_W  = $clog2(LFSR_W + 1);
    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int c_WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [c_FILL_W-1:0]  c_FILL_LAST  = c_FILL_W'(LFSR_W - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
    localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(WIN - 1);
    localparam logic [c_WERR_W-1:0]  c_LOSS       = c_WERR_W'(LOSS_THRESH);

    localparam logic [1:0] c_ST_SEED   = 2'd0;
    localparam logic [1:0] c_ST_SYNC   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]          r_state,     w_state_nxt;
    logic [LFSR_W-1:0]   r_s,         w_s_nxt;
    logic [c_FILL_W-1:0] r_fill,      w_fill_nxt;
    logic [c_MATCH_W-1:0] r_match,    w_match_nxt;
    logic [c_WIN_W-1:0]  r_win,       w_win_nxt;
    logic [c_WERR_W-1:0] r_win_err,   w_win_err_nxt;
    logic                r_locked;
    logic                r_err_pulse, w_err_pulse_nxt;
    logic [CNT_W-1:0]    r_err_count, w_err_count_nxt;
    logic [CNT_W-1:0]    r_bit_count, w_bit_count_nxt;

    logic                w_pred;
    logic                w_miss;
    logic [c_WERR_W-1:0] w_win_err_inc;

    assign w_pred        = r_s[TAP_A-1] ^ r_s[TAP_B-1];
    assign w_miss        = din ^ w_pred;
    assign w_win_err_inc = r_win_err + c_WERR_W'(w_miss);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_SEED;
            r_s         <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_win       <= w_win_nxt;
            r_win_err   <= w_win_err_nxt;
            r_locked    <= (w_state_nxt == c_ST_LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
            r_bit_count <= w_bit_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_fill_nxt      = r_fill;
        w_match_nxt     = r_match;
        w_win_nxt       = r_win;
        w_win_err_nxt   = r_win_err;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = r_err_count;
        w_bit_count_nxt = r_bit_count;

        if (din_valid) begin
            case (r_state)
                c_ST_SEED: begin
                    w_s_nxt = {r_s[LFSR_W-2:0], din};
                    if (r_fill == c_FILL_LAST) begin
                        w_state_nxt = c_ST_SYNC;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill + c_FILL_W'(1);
                    end
                end
                c_ST_SYNC: begin
                    w_s_nxt = {r_s[LFSR_W-2:0], din};
                    // An all-zero register predicts zeros forever; never trust it.
                    if (!w_miss && (r_s != '0)) begin
                        w_match_nxt = r_match + c_MATCH_W'(1);
                        if (r_match == c_MATCH_LAST) begin
                            w_state_nxt   = c_ST_LOCKED;
                            w_win_nxt     = '0;
                            w_win_err_nxt = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                c_ST_LOCKED: begin
                    w_s_nxt = {r_s[LFSR_W-2:0], w_pred};
                    if (r_bit_count != '1) w_bit_count_nxt = r_bit_count + CNT_W'(1);
                    if (w_miss) begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_count != '1) w_err_count_nxt = r_err_count + CNT_W'(1);
                    end
                    if (w_win_err_inc == c_LOSS) begin
                        w_state_nxt = c_ST_SEED;
                        w_fill_nxt  = '0;
                    end
                    // Threshold is judged before the wrap so the window's last bit still counts.
                    if (r_win == c_WIN_LAST) begin
                        w_win_nxt     = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_nxt     = r_win + c_WIN_W'(1);
                        w_win_err_nxt = w_win_err_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_SEED;
                    w_fill_nxt  = '0;
                end
            endcase
        end

        if (clear_counts) begin
            w_err_count_nxt = '0;
            w_bit_count_nxt = '0;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire
